// File: rtl/lsu_pipe_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pipe_pkg;

    // Operation codes presented by the core; anything other than the eight
    // memory ops (e.g. i_LUI) is accepted and silently dropped by the LSU.
    typedef enum logic [3:0] {
        i_LB,
        i_LH,
        i_LW,
        i_LBU,
        i_LHU,
        i_SB,
        i_SH,
        i_SW,
        i_LUI
    } ls_op_t;

    // LSU control states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_t;

    // Exception cause encodings reported on exc_cause.
    localparam logic [1:0] EXC_LD_MISALIGN = 2'b00;
    localparam logic [1:0] EXC_ST_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_BUS_TIMEOUT = 2'b10;

endpackage

// File: rtl/lsu_pipe_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_pipe_if #(
    parameter int ADDR_W = 32
) ();

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wr_data;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    modport master (
        output d_req, d_we, d_be, d_addr, d_wr_data,
        input  d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_be, d_addr, d_wr_data,
        output d_gnt, d_rvalid, d_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane placement, load
// extraction/extension and misalignment detection.
module lsu_align
    import lsu_pipe_pkg::*;
(
    input  ls_op_t      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_result,
    output logic        is_mem,
    output logic        is_store,
    output logic        misaligned
);

    // Read data with the addressed byte moved down to lane 0.
    logic [31:0] shifted;
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Decode the op into enables, store placement, load extension and alignment.
    always_comb begin
        be         = '0;
        wdata      = st_data;
        ld_result  = '0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (op)
            i_LB: begin
                is_mem    = 1'b1;
                be        = 4'b0001 << addr_lo;
                ld_result = {{24{shifted[7]}}, shifted[7:0]};
            end
            i_LBU: begin
                is_mem    = 1'b1;
                be        = 4'b0001 << addr_lo;
                ld_result = {24'b0, shifted[7:0]};
            end
            i_LH: begin
                is_mem     = 1'b1;
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                ld_result  = {{16{shifted[15]}}, shifted[15:0]};
            end
            i_LHU: begin
                is_mem     = 1'b1;
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                ld_result  = {16'b0, shifted[15:0]};
            end
            i_LW: begin
                is_mem     = 1'b1;
                be         = 4'b1111;
                misaligned = |addr_lo;
                ld_result  = shifted;
            end
            i_SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                be       = 4'b0001 << addr_lo;
                wdata    = {4{st_data[7:0]}};
            end
            i_SH: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                be         = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                wdata      = {2{st_data[15:0]}};
            end
            i_SW: begin
                is_mem     = 1'b1;
                is_store   = 1'b1;
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            default: begin
                is_mem = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit: address generation, alignment check,
// request/grant/response sequencing and optional grant timeout.
module lsu_pipe
    import lsu_pipe_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int unsigned GNT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  ls_op_t      ls_op,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        ld_valid,
    output logic [4:0]  ld_rd_addr,
    output logic [31:0] ld_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    lsu_pipe_if.master  dbus
);

    localparam int CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((GNT_TIMEOUT > 0) ? GNT_TIMEOUT - 1 : 0);

    lsu_state_t       state_q, state_n;
    logic [31:0]      ea;
    logic             accept;
    logic             in_req;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      ea_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    ls_op_t           op_q;
    logic [4:0]       rd_q;

    ls_op_t           al_op;
    logic [1:0]       al_addr_lo;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_ld_result;
    logic             al_is_mem;
    logic             al_is_store;
    logic             al_misaligned;

    assign ea          = rs1_data + imm;
    assign issue_ready = (state_q == ST_IDLE);
    assign accept      = issue_valid && issue_ready;
    assign in_req      = (state_q == ST_REQ);
    assign timeout_hit = (GNT_TIMEOUT != 0) && in_req && !dbus.d_gnt &&
                         (cnt_q == CNT_LAST);

    // One aligner serves both ends: in IDLE it decodes the incoming op, in
    // RESP it extracts from read data using the registered op and address.
    assign al_op      = (state_q == ST_IDLE) ? ls_op : op_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? ea[1:0] : ea_q[1:0];

    lsu_align u_align (
        .op         (al_op),
        .addr_lo    (al_addr_lo),
        .st_data    (rs2_data),
        .rdata      (dbus.d_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .ld_result  (al_ld_result),
        .is_mem     (al_is_mem),
        .is_store   (al_is_store),
        .misaligned (al_misaligned)
    );

    // Request fields are only driven while a request is outstanding.
    assign dbus.d_req     = in_req;
    assign dbus.d_we      = in_req && we_q;
    assign dbus.d_be      = in_req ? be_q : '0;
    assign dbus.d_addr    = in_req ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
    assign dbus.d_wr_data = in_req ? wdata_q : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && al_is_mem && !al_misaligned) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dbus.d_gnt) begin
                    state_n = we_q ? ST_IDLE : ST_RESP;
                end else if (timeout_hit) begin
                    state_n = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (dbus.d_rvalid) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Grant-wait counter, cleared whenever the unit is not waiting in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_req && (state_n == ST_REQ)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Op capture, exception and load-writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea_q       <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            op_q       <= i_LB;
            rd_q       <= '0;
            ld_valid   <= 1'b0;
            ld_rd_addr <= '0;
            ld_data    <= '0;
            exc_valid  <= 1'b0;
            exc_cause  <= '0;
            exc_addr   <= '0;
        end else begin
            ld_valid  <= 1'b0;
            exc_valid <= 1'b0;
            if (accept && al_is_mem) begin
                ea_q    <= ea;
                we_q    <= al_is_store;
                be_q    <= al_be;
                wdata_q <= al_wdata;
                op_q    <= ls_op;
                rd_q    <= rd_addr;
                if (al_misaligned) begin
                    exc_valid <= 1'b1;
                    exc_cause <= al_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                    exc_addr  <= ea;
                end
            end
            if (timeout_hit) begin
                exc_valid <= 1'b1;
                exc_cause <= EXC_BUS_TIMEOUT;
                exc_addr  <= ea_q;
            end
            if ((state_q == ST_RESP) && dbus.d_rvalid) begin
                ld_valid   <= 1'b1;
                ld_rd_addr <= rd_q;
                ld_data    <= al_ld_result;
            end
        end
    end

endmodule

// File: tb/tb_lsu_pipe.sv
// Self-checking bench for lsu_pipe: directed scenarios followed by random ops
// checked against a size/lane arithmetic reference model.
module tb_lsu_pipe;
    import lsu_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    ls_op_t      ls_op;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        ld_valid;
    logic [4:0]  ld_rd_addr;
    logic [31:0] ld_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int checks = 0;
    int errors = 0;

    lsu_pipe_if #(.ADDR_W(32)) bus ();

    lsu_pipe #(.ADDR_W(32), .GNT_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .ls_op       (ls_op),
        .rd_addr     (rd_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .ld_valid    (ld_valid),
        .ld_rd_addr  (ld_rd_addr),
        .ld_data     (ld_data),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_addr    (exc_addr),
        .dbus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory ops.
    function automatic int unsigned op_size(input ls_op_t op);
        case (op)
            i_LB, i_LBU, i_SB: return 1;
            i_LH, i_LHU, i_SH: return 2;
            i_LW, i_SW:        return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_store(input ls_op_t op);
        return (op == i_SB) || (op == i_SH) || (op == i_SW);
    endfunction

    function automatic bit op_signed(input ls_op_t op);
        return (op == i_LB) || (op == i_LH);
    endfunction

    function automatic logic [31:0] model_load(input ls_op_t op, input int unsigned lane,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int unsigned sz;
        sz = op_size(op);
        v  = rdata >> (8 * lane);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op_signed(op) && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op_signed(op) && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Issue one op and follow it through to completion, checking every cycle.
    // gnt_dly >= 8 means the memory never grants.
    task automatic do_op(input ls_op_t op, input logic [31:0] a_rs1, input logic [31:0] a_imm,
                         input logic [31:0] a_rs2, input logic [4:0] a_rd,
                         input int unsigned gnt_dly, input int unsigned rv_dly,
                         input logic [31:0] a_rdata);
        logic [31:0] ea;
        logic [3:0]  be;
        int unsigned sz, lane;
        bit          granted;
        ea   = a_rs1 + a_imm;
        sz   = op_size(op);
        lane = ea % 4;
        be   = 4'(((1 << sz) - 1) << lane);

        chk("issue_ready_before", 32'(issue_ready), 1);
        issue_valid = 1'b1;
        ls_op       = op;
        rs1_data    = a_rs1;
        imm         = a_imm;
        rs2_data    = a_rs2;
        rd_addr     = a_rd;
        @(negedge clk);
        issue_valid = 1'b0;
        rs2_data    = $urandom;

        if (sz == 0) begin
            chk("nonmem_d_req", 32'(bus.d_req), 0);
            chk("nonmem_exc", 32'(exc_valid), 0);
            chk("nonmem_ready", 32'(issue_ready), 1);
            return;
        end
        if ((ea % sz) != 0) begin
            chk("mis_d_req", 32'(bus.d_req), 0);
            chk("mis_exc_valid", 32'(exc_valid), 1);
            chk("mis_cause", 32'(exc_cause), op_store(op) ? 1 : 0);
            chk("mis_addr", exc_addr, ea);
            chk("mis_ld_valid", 32'(ld_valid), 0);
            chk("mis_ready", 32'(issue_ready), 1);
            @(negedge clk);
            chk("mis_exc_pulse", 32'(exc_valid), 0);
            return;
        end

        granted = 1'b0;
        for (int k = 0; k < 8 && !granted; k++) begin
            chk("req_d_req", 32'(bus.d_req), 1);
            chk("req_d_addr", bus.d_addr, {ea[31:2], 2'b00});
            chk("req_d_be", 32'(bus.d_be), 32'(be));
            chk("req_d_we", 32'(bus.d_we), 32'(op_store(op)));
            chk("req_ready", 32'(issue_ready), 0);
            chk("req_exc", 32'(exc_valid), 0);
            if (op_store(op)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) chk("req_wr_lane", 32'(bus.d_wr_data[8*i +: 8]),
                                   32'(a_rs2[8*(i - int'(lane)) +: 8]));
                end
            end
            if (k == int'(gnt_dly)) bus.d_gnt = 1'b1;
            else bus.d_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.d_gnt    = 1'b0;
            bus.d_rvalid = 1'b0;
            if (k == int'(gnt_dly)) granted = 1'b1;
        end

        chk("post_req_d_req", 32'(bus.d_req), 0);
        chk("post_req_ld_valid", 32'(ld_valid), 0);
        if (!granted) begin
            chk("tmo_exc_valid", 32'(exc_valid), 1);
            chk("tmo_cause", 32'(exc_cause), 2);
            chk("tmo_addr", exc_addr, ea);
            chk("tmo_ready", 32'(issue_ready), 1);
            @(negedge clk);
            chk("tmo_exc_pulse", 32'(exc_valid), 0);
            return;
        end
        chk("gnt_exc", 32'(exc_valid), 0);
        if (op_store(op)) begin
            chk("st_done_ready", 32'(issue_ready), 1);
            return;
        end

        chk("resp_ready", 32'(issue_ready), 0);
        for (int k = 0; k < int'(rv_dly); k++) begin
            bus.d_gnt = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.d_gnt = 1'b0;
            chk("resp_wait_ld_valid", 32'(ld_valid), 0);
            chk("resp_wait_d_req", 32'(bus.d_req), 0);
        end
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = a_rdata;
        @(negedge clk);
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = $urandom;
        chk("ld_valid", 32'(ld_valid), 1);
        chk("ld_data", ld_data, model_load(op, lane, a_rdata));
        chk("ld_rd_addr", 32'(ld_rd_addr), 32'(a_rd));
        chk("ld_exc", 32'(exc_valid), 0);
        chk("ld_ready", 32'(issue_ready), 1);
        @(negedge clk);
        chk("ld_valid_pulse", 32'(ld_valid), 0);
    endtask

    initial begin
        rst          = 1'b1;
        issue_valid  = 1'b0;
        ls_op        = i_LUI;
        rd_addr      = '0;
        rs1_data     = '0;
        rs2_data     = '0;
        imm          = '0;
        bus.d_gnt    = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_d_req", 32'(bus.d_req), 0);
        chk("rst_d_be", 32'(bus.d_be), 0);
        chk("rst_ld_valid", 32'(ld_valid), 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_exc_valid", 32'(exc_valid), 0);
        chk("rst_exc_addr", exc_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Word load, immediate grant, data three cycles later.
        do_op(i_LW, 32'h100, 32'h4, 32'h0, 5'd5, 0, 3, 32'hDEAD_BEEF);
        // Byte loads from the top lane, signed and unsigned.
        do_op(i_LB, 32'h200, 32'h3, 32'h0, 5'd6, 0, 0, 32'h8000_0000);
        do_op(i_LBU, 32'h200, 32'h3, 32'h0, 5'd7, 0, 1, 32'h8000_0000);
        // Halfword store to the upper lane with a delayed grant.
        do_op(i_SH, 32'h100, 32'h2, 32'h1234, 5'd0, 4, 0, 32'h0);
        // Misaligned word load and store.
        do_op(i_LW, 32'h100, 32'h1, 32'h0, 5'd3, 0, 0, 32'h0);
        do_op(i_SW, 32'h100, 32'h2, 32'h55AA, 5'd0, 0, 0, 32'h0);
        // Non-memory op is dropped.
        do_op(i_LUI, 32'h0, 32'h1000, 32'h0, 5'd9, 0, 0, 32'h0);
        // Grant timeout, then grant on the last allowed cycle.
        do_op(i_LW, 32'h300, 32'h0, 32'h0, 5'd10, 8, 0, 32'h0);
        do_op(i_LW, 32'h300, 32'h0, 32'h0, 5'd11, 7, 0, 32'h1357_9BDF);
        do_op(i_LHU, 32'h402, 32'h0, 32'h0, 5'd12, 1, 2, 32'hF00D_8001);

        // Reset while waiting for read data, then a stray d_rvalid.
        issue_valid = 1'b1;
        ls_op       = i_LW;
        rs1_data    = 32'h500;
        imm         = 32'h0;
        rd_addr     = 5'd13;
        @(negedge clk);
        issue_valid = 1'b0;
        bus.d_gnt   = 1'b1;
        @(negedge clk);
        bus.d_gnt = 1'b0;
        chk("resp_before_rst", 32'(issue_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(issue_ready), 1);
        chk("async_rst_d_req", 32'(bus.d_req), 0);
        chk("async_rst_d_addr", bus.d_addr, 0);
        chk("async_rst_ld_valid", 32'(ld_valid), 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.d_rvalid = 1'b0;
        chk("stray_rvalid_ld", 32'(ld_valid), 0);
        @(negedge clk);
        chk("stray_rvalid_ld2", 32'(ld_valid), 0);
        do_op(i_LW, 32'h600, 32'h8, 32'h0, 5'd14, 0, 0, 32'h0BAD_F00D);

        // Random ops.
        for (int n = 0; n < 80; n++) begin
            ls_op_t      rop;
            logic [31:0] rbase;
            rop   = ls_op_t'($urandom_range(0, 8));
            rbase = $urandom;
            if ($urandom_range(0, 1) == 1) rbase[1:0] = 2'b00;
            do_op(rop, rbase, 32'($urandom_range(0, 3)), $urandom, 5'($urandom),
                  $urandom_range(0, 9), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_pipe.md
LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 Parameter: ADDR_W, 32, data-memory address width (ADDR_W >= 3 and <= 32).
REQ-002 Parameter: GNT_TIMEOUT, 0, cycles to wait for d_gnt before flagging a bus error (0 = never time out).
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: issue_valid  in  1  core presents a memory op.
REQ-006 Port: issue_ready  out  1  unit can accept an op this cycle.
REQ-007 Port: ls_op  in  ls_op_t  operation code.
REQ-008 Port: rd_addr  in  5  load destination register.
REQ-009 Port: rs1_data, rs2_data, imm  in  32 each  base, store data, offset.
REQ-010 Port: ld_valid  out  1  one-cycle load-writeback strobe.
REQ-011 Port: ld_rd_addr  out  5  destination register for ld_data.
REQ-012 Port: ld_data  out  32  extended load result.
REQ-013 Port: exc_valid  out  1  one-cycle exception strobe.
REQ-014 Port: exc_cause  out  2  00 load misaligned, 01 store misaligned, 10 bus timeout.
REQ-015 Port: exc_addr  out  32  effective address of the faulting op.
REQ-016 Port: d_req, d_we  out  1 each  memory request and write qualifier.
REQ-017 Port: d_be  out  4  byte enables.
REQ-018 Port: d_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
REQ-019 Port: d_wr_data  out  32  lane-shifted store data.
REQ-020 Port: d_gnt, d_rvalid  in  1 each  request accepted, read data valid.
REQ-021 Port: d_rdata  in  32  read data.

Function
REQ-022 FSM states: IDLE, REQ, RESP; issue_ready = 1 only in IDLE.
REQ-023 Effective address ea = rs1_data + imm, modulo 2^32. d_addr = {ea[ADDR_W-1:2], 2'b00}.
REQ-024 An op is accepted on issue_valid && issue_ready. Address, op, rd_addr and store data are registered.
REQ-025 Non-memory ls_op values (e.g. i_LUI) are accepted and dropped. No request, strobe or state change.
REQ-026 Byte enables: byte 0001 << ea[1:0]; half 0011 << ea[1:0]; word 1111. Store data is replicated or shifted into the addressed lane.
REQ-027 Misalignment: half with ea[0] = 1, or word with ea[1:0] != 0.
REQ-028 On an accepted misaligned op: no d_req; exc_valid pulses the next cycle with the correct cause and exc_addr = ea; FSM stays IDLE.
REQ-029 In REQ: d_req = 1, and d_we, d_be, d_addr, d_wr_data are held stable until d_gnt.
REQ-030 Store with d_gnt: go to IDLE the next cycle; no ld_valid.
REQ-031 Load with d_gnt: go to RESP.
REQ-032 In RESP: wait on d_rvalid. Extract the addressed byte/half from d_rdata, sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-033 ld_valid pulses one cycle after d_rvalid is sampled, with ld_rd_addr and ld_data registered; FSM then returns to IDLE.
REQ-034 d_gnt in IDLE/RESP and d_rvalid in IDLE/REQ are ignored.
REQ-035 Timeout, GNT_TIMEOUT > 0: a counter runs in REQ. At GNT_TIMEOUT cycles without d_gnt: drop d_req, pulse exc_valid with cause 10, go to IDLE.
REQ-036 d_gnt in the same cycle the counter expires counts as a grant; no exception.
REQ-037 Best-case latency: accept -> d_req next cycle; load ld_valid 1 cycle after d_rvalid; store done 1 cycle after d_gnt.
REQ-038 exc_valid and ld_valid are never both high.

Reset
REQ-039 Asynchronous assertion of rst forces IDLE and zeroes all outputs; issue_ready = 1 after reset; timeout counter cleared.
REQ-040 Reset mid-REQ or mid-RESP abandons the op. A later stray d_rvalid produces no ld_valid.

Structure
REQ-041 The shared package holds ls_op_t (LB, LH, LW, LBU, LHU, SB, SH, SW, LUI), the lsu state enum and the exception-cause constants.
REQ-042 One sub-module, lsu_align: combinational byte-enable, store-lane shifting, load extraction and extension, and misalign detection.

Verification
REQ-043 LW with rs1 = 0x100, imm = 4; d_gnt immediate; d_rvalid 3 cycles later with d_rdata = 0xDEADBEEF -> d_addr = 0x104, d_be = 1111, ld_data = 0xDEADBEEF one cycle after d_rvalid.
REQ-044 LB with ea = 0x203, d_rdata = 0x80000000 -> d_be = 1000, ld_data = 0xFFFFFF80. Same with LBU -> ld_data = 0x00000080.
REQ-045 SH with ea = 0x102, rs2 = 0x1234, d_gnt delayed 4 cycles -> d_be = 1100, d_wr_data[31:16] = 0x1234; request fields stable until d_gnt; no ld_valid.
REQ-046 LW with ea = 0x101 -> no d_req; exc_valid with cause 00 and exc_addr = 0x101 one cycle after accept; issue_ready stays 1.
REQ-047 GNT_TIMEOUT = 8, d_gnt never asserted -> d_req high 8 cycles, then exc_valid with cause 10. Repeat with d_gnt on cycle 8 -> grant, no exception.
REQ-048 rst asserted in RESP, then d_rvalid pulsed -> outputs zero immediately, no ld_valid; the next LW completes normally.
